// File: rtl/isqrt_arb_pkg.sv
// Shared widths and helpers for the isqrt request arbiter and its tag FIFO.
package isqrt_arb_pkg;

    // Operand and result widths of the shared isqrt unit.
    localparam int ISQRT_X_W = 32;
    localparam int ISQRT_Y_W = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int tag_width(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

endpackage

// File: rtl/isqrt_tag_fifo.sv
// Synchronous tag FIFO: remembers which requester owns each in-flight op.
// Push and pop may happen in the same cycle, including when the FIFO is full.
module isqrt_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state for the pointers and occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count and pointers alone decide which entries are meaningful.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one pipelined isqrt unit between N_REQ requesters.
// Results come back in issue order; a tag FIFO routes each one to its owner.
module isqrt_rr_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_vld,
    input  logic [N_REQ*ISQRT_X_W-1:0]     req_x,
    output logic [N_REQ-1:0]               req_rdy,
    output logic [N_REQ-1:0]               rsp_vld,
    output logic [N_REQ*ISQRT_Y_W-1:0]     rsp_y,
    output logic                           isqrt_x_vld,
    output logic [ISQRT_X_W-1:0]           isqrt_x,
    input  logic                           isqrt_y_vld,
    input  logic [ISQRT_Y_W-1:0]           isqrt_y,
    output logic [$clog2(DEPTH+1)-1:0]     inflight,
    output logic                           err_orphan
);

    localparam int TAG_W = tag_width(N_REQ);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Registered state.
    logic [TAG_W-1:0]               ptr_q, ptr_d;
    logic [N_REQ-1:0]               rsp_vld_q, rsp_vld_d;
    logic [N_REQ*ISQRT_Y_W-1:0]     rsp_y_q, rsp_y_d;
    logic                           err_q, err_d;

    // Arbitration.
    logic                           can_issue;
    logic [N_REQ-1:0]               rdy_c;
    logic [N_REQ-1:0]               grant_c;
    logic [TAG_W-1:0]               grant_idx_c;
    logic [TAG_W-1:0]               scan_idx_c;
    logic                           seen_c;

    // Tag FIFO interface.
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [TAG_W-1:0]               head_tag;
    logic [CNT_W-1:0]               fifo_count;
    logic                           fifo_pop;
    logic                           orphan;

    // A returning result frees a slot this cycle, so a full FIFO may still issue.
    assign can_issue = !fifo_full || isqrt_y_vld;

    // Priority scan from ptr: a requester is ready when no higher-priority requester is
    // asking. Its own valid is never consulted, so there is no loop through its handshake.
    always_comb begin
        rdy_c       = '0;
        grant_idx_c = '0;
        scan_idx_c  = '0;
        seen_c      = 1'b0;
        // NOTE: blocking assignments on purpose: each iteration must see seen_c as left by the previous one.
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx_c = TAG_W'((int'(ptr_q) + k) % N_REQ);
            rdy_c[scan_idx_c] = can_issue && !seen_c;
            if (req_vld[scan_idx_c] && !seen_c) begin
                grant_idx_c = scan_idx_c;
            end
            seen_c = seen_c || req_vld[scan_idx_c];
        end
    end

    assign grant_c     = rdy_c & req_vld;
    assign req_rdy     = rdy_c;
    assign isqrt_x_vld = |grant_c;

    // Operand mux for the granted requester; don't-care when nothing issues.
    always_comb begin
        isqrt_x = 'x;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                isqrt_x = req_x[i*ISQRT_X_W +: ISQRT_X_W];
            end
        end
    end

    // Tag FIFO: push the winner on issue, pop on each returning result.
    isqrt_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (isqrt_x_vld),
        .push_data_i (grant_idx_c),
        .pop_i       (isqrt_y_vld),
        .head_o      (head_tag),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign inflight = fifo_count;

    // A result with nothing outstanding is an orphan; an op pushed this cycle cannot claim it.
    assign fifo_pop = isqrt_y_vld && !fifo_empty;
    assign orphan   = isqrt_y_vld && fifo_empty;

    // Next pointer, routed response and sticky error.
    always_comb begin
        ptr_d     = ptr_q;
        rsp_vld_d = '0;
        rsp_y_d   = rsp_y_q;
        err_d     = err_q || orphan;
        if (isqrt_x_vld) begin
            ptr_d = (grant_idx_c == TAG_W'(N_REQ - 1)) ? '0 : grant_idx_c + TAG_W'(1);
        end
        if (fifo_pop) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (head_tag == TAG_W'(i)) begin
                    rsp_vld_d[i]                      = 1'b1;
                    rsp_y_d[i*ISQRT_Y_W +: ISQRT_Y_W] = isqrt_y;
                end
            end
        end
    end

    // State registers; reset abandons anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            rsp_vld_q <= '0;
            rsp_y_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_y_q   <= rsp_y_d;
            err_q     <= err_d;
        end
    end

    assign rsp_vld    = rsp_vld_q;
    assign rsp_y      = rsp_y_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// Bench for isqrt_rr_arbiter: a fixed-latency isqrt pipeline stands in for the
// shared unit, and a queue-based scoreboard predicts grants and routed results.
module tb_isqrt_rr_arbiter;

    localparam int N     = 2;
    localparam int DEPTH = 4;
    localparam int LAT   = 6;
    localparam int CW    = $clog2(DEPTH+1);

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N*32-1:0] req_x;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    rsp_vld;
    logic [N*16-1:0] rsp_y;
    logic            isqrt_x_vld;
    logic [31:0]     isqrt_x;
    logic            isqrt_y_vld;
    logic [15:0]     isqrt_y;
    logic [CW-1:0]   inflight;
    logic            err_orphan;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 0;

    isqrt_rr_arbiter #(.N_REQ(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_x       (req_x),
        .req_rdy     (req_rdy),
        .rsp_vld     (rsp_vld),
        .rsp_y       (rsp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .inflight    (inflight),
        .err_orphan  (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Integer square root, built bit by bit from the top.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] cand;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            cand = r | (16'd1 << b);
            if ({16'd0, cand} * {16'd0, cand} <= x) r = cand;
        end
        return r;
    endfunction

    // ---------------- isqrt unit stand-in: LAT-stage pipeline ----------------
    logic        pv [LAT];
    logic [15:0] py [LAT];
    logic        iss_vld_s;
    logic [31:0] iss_x_s;
    logic        inj_vld;
    logic [15:0] inj_y;

    always @(negedge clk) begin
        iss_vld_s = isqrt_x_vld;
        iss_x_s   = isqrt_x;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                pv[s] <= 1'b0;
                py[s] <= '0;
            end
        end else begin
            for (int s = LAT-1; s > 0; s--) begin
                pv[s] <= pv[s-1];
                py[s] <= py[s-1];
            end
            pv[0] <= (iss_vld_s === 1'b1);
            py[0] <= ref_sqrt(iss_x_s);
        end
    end

    assign isqrt_y_vld = pv[LAT-1] | inj_vld;
    assign isqrt_y     = inj_vld ? inj_y : py[LAT-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        int          tag;
        logic [15:0] y;
    } op_t;

    op_t             m_q[$];
    int              m_ptr;
    bit              m_err;
    logic [N-1:0]    m_rsp_vld;
    logic [N*16-1:0] m_rsp_y;

    always @(negedge clk) begin : scoreboard
        int           w;
        bit           can;
        op_t          e;
        logic [N-1:0] exp_acc;
        logic [N-1:0] nxt_vld;
        w   = -1;
        can = (m_q.size() < DEPTH) || (isqrt_y_vld === 1'b1);
        if (can) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_vld[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        exp_acc = '0;
        if (w >= 0) exp_acc[w] = 1'b1;

        if (chk_en) begin
            n_vec++;
            if ((req_rdy & req_vld) !== exp_acc) begin
                n_err++;
                $display("FAIL sb_accept cyc=%0d got %b exp %b", cyc, req_rdy & req_vld, exp_acc);
            end
            n_vec++;
            if (isqrt_x_vld !== (w >= 0)) begin
                n_err++;
                $display("FAIL sb_issue_vld cyc=%0d got %b exp %b", cyc, isqrt_x_vld, (w >= 0));
            end
            if (w >= 0) begin
                n_vec++;
                if (isqrt_x !== req_x[32*w +: 32]) begin
                    n_err++;
                    $display("FAIL sb_issue_x cyc=%0d got %0d exp %0d", cyc, isqrt_x, req_x[32*w +: 32]);
                end
            end
            n_vec++;
            if (rsp_vld !== m_rsp_vld) begin
                n_err++;
                $display("FAIL sb_rsp_vld cyc=%0d got %b exp %b", cyc, rsp_vld, m_rsp_vld);
            end
            n_vec++;
            if (rsp_y !== m_rsp_y) begin
                n_err++;
                $display("FAIL sb_rsp_y cyc=%0d got %h exp %h", cyc, rsp_y, m_rsp_y);
            end
            n_vec++;
            if (inflight !== CW'(m_q.size())) begin
                n_err++;
                $display("FAIL sb_inflight cyc=%0d got %0d exp %0d", cyc, inflight, m_q.size());
            end
            n_vec++;
            if (err_orphan !== m_err) begin
                n_err++;
                $display("FAIL sb_err_orphan cyc=%0d got %b exp %b", cyc, err_orphan, m_err);
            end
        end

        // Advance the model to the state after the coming clock edge.
        if (rst === 1'b1) begin
            m_q.delete();
            m_ptr     = 0;
            m_err     = 1'b0;
            m_rsp_vld = '0;
            m_rsp_y   = '0;
        end else begin
            nxt_vld = '0;
            if (isqrt_y_vld === 1'b1) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    nxt_vld[e.tag] = 1'b1;
                    m_rsp_y[16*e.tag +: 16] = e.y;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (w >= 0) begin
                e.tag = w;
                e.y   = ref_sqrt(req_x[32*w +: 32]);
                m_q.push_back(e);
                m_ptr = (w + 1) % N;
            end
            m_rsp_vld = nxt_vld;
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_vld = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge clk);
        while ((inflight !== '0 || rsp_vld !== '0) && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 60) begin
            n_err++;
            $display("FAIL drain_timeout got inflight=%0d exp 0", inflight);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req_vld = '0; req_x = '0; inj_vld = 1'b0; inj_y = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        n_vec++; if (inflight !== '0)   begin n_err++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        n_vec++; if (rsp_vld !== '0)    begin n_err++; $display("FAIL reset_rsp_vld got %b exp 0", rsp_vld); end
        n_vec++; if (rsp_y !== '0)      begin n_err++; $display("FAIL reset_rsp_y got %h exp 0", rsp_y); end
        n_vec++; if (err_orphan !== 0)  begin n_err++; $display("FAIL reset_err got %b exp 0", err_orphan); end
        n_vec++; if (isqrt_x_vld !== 0) begin n_err++; $display("FAIL reset_issue got %b exp 0", isqrt_x_vld); end
    endtask

    task automatic test_single();
        int t_acc;
        int k;
        @(posedge clk); #1;
        req_vld = 2'b01;
        req_x   = {32'd0, 32'd144};
        @(negedge clk);
        t_acc = cyc;
        n_vec++; if (req_rdy !== 2'b01)   begin n_err++; $display("FAIL single_rdy got %b exp 01", req_rdy); end
        n_vec++; if (isqrt_x !== 32'd144) begin n_err++; $display("FAIL single_x got %0d exp 144", isqrt_x); end
        @(posedge clk); #1 req_vld = '0;
        @(negedge clk);
        n_vec++; if (inflight !== CW'(1)) begin n_err++; $display("FAIL single_inflight1 got %0d exp 1", inflight); end
        k = 0;
        while (rsp_vld === '0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 30) begin
            n_err++; $display("FAIL single_timeout got no rsp exp rsp within 30 cycles");
        end else begin
            n_vec++; if (rsp_vld !== 2'b01)        begin n_err++; $display("FAIL single_rsp_vld got %b exp 01", rsp_vld); end
            n_vec++; if (rsp_y[15:0] !== 16'd12)   begin n_err++; $display("FAIL single_rsp_y got %0d exp 12", rsp_y[15:0]); end
            n_vec++; if (cyc - t_acc !== LAT + 1)  begin n_err++; $display("FAIL single_latency got %0d exp %0d", cyc - t_acc, LAT + 1); end
            n_vec++; if (inflight !== '0)          begin n_err++; $display("FAIL single_inflight0 got %0d exp 0", inflight); end
        end
        drain();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g;
        int got;
        int k;
        pulse_reset();
        req_vld = 2'b11;
        req_x   = {32'd81, 32'd16};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_vec++;
            if (req_rdy !== exp_g) begin
                n_err++; $display("FAIL contention_grant%0d got %b exp %b", c, req_rdy, exp_g);
            end
        end
        @(posedge clk); #1 req_vld = '0;
        got = 0;
        k   = 0;
        while (got < 4 && k < 40) begin
            @(negedge clk);
            k++;
            if (rsp_vld !== '0) begin
                exp_g = (got % 2 == 0) ? 2'b01 : 2'b10;
                n_vec++;
                if (rsp_vld !== exp_g) begin
                    n_err++; $display("FAIL contention_rsp%0d got %b exp %b", got, rsp_vld, exp_g);
                end
                n_vec++;
                if (exp_g == 2'b01 && rsp_y[15:0] !== 16'd4) begin
                    n_err++; $display("FAIL contention_y%0d got %0d exp 4", got, rsp_y[15:0]);
                end else if (exp_g == 2'b10 && rsp_y[31:16] !== 16'd9) begin
                    n_err++; $display("FAIL contention_y%0d got %0d exp 9", got, rsp_y[31:16]);
                end
                got++;
            end
        end
        n_vec++;
        if (got != 4) begin
            n_err++; $display("FAIL contention_count got %0d exp 4", got);
        end
        drain();
    endtask

    task automatic test_fairness();
        @(posedge clk); #1;
        req_vld = 2'b10;
        req_x   = {32'd49, 32'd25};
        @(negedge clk);
        n_vec++; if ((req_rdy & req_vld) !== 2'b10) begin n_err++; $display("FAIL fair_solo got %b exp 10", req_rdy & req_vld); end
        @(posedge clk); #1 req_vld = '0;
        repeat (3) @(posedge clk);
        #1 req_vld = 2'b11;
        @(negedge clk);
        n_vec++; if ((req_rdy & req_vld) !== 2'b01) begin n_err++; $display("FAIL fair_after_idle got %b exp 01", req_rdy & req_vld); end
        @(posedge clk); #1 req_vld = '0;
        drain();
        pulse_reset();
        req_vld = 2'b11;
        @(negedge clk);
        n_vec++; if ((req_rdy & req_vld) !== 2'b01) begin n_err++; $display("FAIL fair_after_reset got %b exp 01", req_rdy & req_vld); end
        @(posedge clk); #1 req_vld = '0;
        drain();
    endtask

    task automatic test_full();
        @(posedge clk); #1;
        req_vld = 2'b11;
        req_x   = {$urandom, $urandom};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 4) begin
                n_vec++;
                if ($countones(req_rdy & req_vld) != 1) begin
                    n_err++; $display("FAIL full_issue%0d got %b exp one-hot", c, req_rdy & req_vld);
                end
            end else if (c < 6) begin
                n_vec++;
                if (req_rdy !== '0) begin
                    n_err++; $display("FAIL full_stall%0d got %b exp 00", c, req_rdy);
                end
            end else if (c == 6) begin
                n_vec++;
                if (isqrt_y_vld !== 1'b1 || $countones(req_rdy & req_vld) != 1) begin
                    n_err++; $display("FAIL full_pop_issue got y_vld=%b acc=%b exp y_vld=1 one-hot", isqrt_y_vld, req_rdy & req_vld);
                end
            end else begin
                n_vec++;
                if (inflight !== CW'(4)) begin
                    n_err++; $display("FAIL full_inflight got %0d exp 4", inflight);
                end
            end
            @(posedge clk); #1 req_x = {$urandom, $urandom};
        end
        req_vld = '0;
        drain();
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        req_vld = 2'b01;
        req_x   = {32'd0, $urandom};
        repeat (3) @(negedge clk);
        @(posedge clk); #1 req_vld = '0;
        @(negedge clk);
        n_vec++; if (inflight !== CW'(3)) begin n_err++; $display("FAIL mid_inflight3 got %0d exp 3", inflight); end
        pulse_reset();
        @(negedge clk);
        n_vec++; if (inflight !== '0)  begin n_err++; $display("FAIL mid_inflight0 got %0d exp 0", inflight); end
        n_vec++; if (err_orphan !== 0) begin n_err++; $display("FAIL mid_err got %b exp 0", err_orphan); end
        for (int c = 0; c < 12; c++) begin
            n_vec++;
            if (rsp_vld !== '0) begin
                n_err++; $display("FAIL mid_no_rsp%0d got %b exp 00", c, rsp_vld);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 req_vld = 2'b11;
        @(negedge clk);
        n_vec++; if ((req_rdy & req_vld) !== 2'b01) begin n_err++; $display("FAIL mid_ptr got %b exp 01", req_rdy & req_vld); end
        @(posedge clk); #1 req_vld = '0;
        drain();
    endtask

    task automatic test_orphan();
        int k;
        @(posedge clk); #1;
        inj_vld = 1'b1;
        inj_y   = 16'd5;
        @(posedge clk); #1 inj_vld = 1'b0;
        @(negedge clk);
        n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
        n_vec++; if (rsp_vld !== '0)      begin n_err++; $display("FAIL orphan_rsp got %b exp 00", rsp_vld); end
        n_vec++; if (inflight !== '0)     begin n_err++; $display("FAIL orphan_inflight got %0d exp 0", inflight); end
        @(posedge clk); #1;
        req_vld = 2'b10;
        req_x   = {32'd400, 32'd0};
        @(posedge clk); #1 req_vld = '0;
        k = 0;
        while (rsp_vld === '0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 30 || rsp_y[31:16] !== 16'd20) begin
            n_err++; $display("FAIL orphan_followup got %0d exp 20", rsp_y[31:16]);
        end
        n_vec++; if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
        drain();
        pulse_reset();
        @(negedge clk);
        n_vec++; if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orphan_clear got %b exp 0", err_orphan); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            req_vld = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_x[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            end
        end
        @(posedge clk); #1 req_vld = '0;
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_full();
        test_reset_midflight();
        test_orphan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
